// File: rtl/scu_pkg.sv
// ============================================================================
//  Module      : scu_pkg
//  Description : Shared definitions for the simple control unit: opcode
//                encodings and the instruction-phase state enumeration.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package scu_pkg;

    // 3-bit opcode field, the top three bits of the instruction word
    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_ILL = 3'b111;

    // Instruction phases: T0 fetch/idle, T1..T3 execution steps
    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

endpackage : scu_pkg

`default_nettype wire

// File: rtl/scu_reg.sv
// ============================================================================
//  Module      : scu_reg
//  Description : DATA_W-bit register with load enable and synchronous clear.
//                Clear has priority over load.
//  Ports       : clk  - clock
//                rst  - synchronous active-high clear
//                i_ld - load enable
//                i_d  - load data
//                o_q  - register contents
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module scu_reg #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_ld,
    input  logic [DATA_W-1:0] i_d,
    output logic [DATA_W-1:0] o_q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            o_q <= '0;
        end else if (i_ld) begin
            o_q <= i_d;
        end
    end

endmodule : scu_reg

`default_nettype wire

// File: rtl/scu_param.sv
// ============================================================================
//  Module      : scu_param
//  Description : Parametrised multi-cycle control unit with NREG general
//                registers, an accumulator A, a result register G, a single
//                internal bus and a five-function ALU.
//  Ports       : clk      - clock, rising edge
//                Reset    - synchronous active-high reset
//                Run      - instruction start, sampled in T0 only
//                Din      - instruction word (T0) / immediate (T1)
//                dbg_sel  - register select for dbg_data
//                dbg_data - combinational contents of R[dbg_sel]
//                Bus      - internal bus value
//                Done     - final cycle of an instruction
//                Busy     - unit is not in T0
//                Zero     - last ALU result was zero (registered)
//                Illegal  - undefined opcode pulse
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module scu_param
    import scu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NREG   = 8,
    localparam int RSEL_W = $clog2(NREG),
    localparam int IR_W   = 3 + 2 * RSEL_W
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              Run,
    input  logic [DATA_W-1:0] Din,
    input  logic [RSEL_W-1:0] dbg_sel,
    output logic [DATA_W-1:0] dbg_data,
    output logic [DATA_W-1:0] Bus,
    output logic              Done,
    output logic              Busy,
    output logic              Zero,
    output logic              Illegal
);

    // Elaboration guards: the instruction word must fit in Din and the
    // register file must be fully addressed by the select fields.
    if (DATA_W < IR_W) begin : g_bad_width
        $error("scu_param: DATA_W (%0d) smaller than IR_W (%0d)", DATA_W, IR_W);
    end
    if (NREG != 2 && NREG != 4 && NREG != 8) begin : g_bad_nreg
        $error("scu_param: NREG (%0d) must be 2, 4 or 8", NREG);
    end

    state_t              r_state;
    state_t              w_state_nxt;
    logic [IR_W-1:0]     r_ir;
    logic                r_zero;

    logic [2:0]          w_op;
    logic [RSEL_W-1:0]   w_rx;
    logic [RSEL_W-1:0]   w_ry;

    logic [DATA_W-1:0]   w_r [NREG];
    logic [NREG-1:0]     w_r_ld;
    logic [DATA_W-1:0]   w_a;
    logic [DATA_W-1:0]   w_g;
    logic                w_a_ld;
    logic                w_g_ld;
    logic                w_zero_ld;

    logic [DATA_W-1:0]   w_bus;
    logic [DATA_W-1:0]   w_alu;
    logic                w_done;
    logic                w_illegal;

    assign w_op = r_ir[IR_W-1 -: 3];
    assign w_rx = r_ir[2*RSEL_W-1 -: RSEL_W];
    assign w_ry = r_ir[RSEL_W-1:0];

    // ------------------------------------------------------------------
    // Register file, accumulator and result register
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
        scu_reg #(.DATA_W(DATA_W)) u_r (
            .clk  (clk),
            .rst  (Reset),
            .i_ld (w_r_ld[gi]),
            .i_d  (w_bus),
            .o_q  (w_r[gi])
        );
    end

    scu_reg #(.DATA_W(DATA_W)) u_a (
        .clk  (clk),
        .rst  (Reset),
        .i_ld (w_a_ld),
        .i_d  (w_bus),
        .o_q  (w_a)
    );

    scu_reg #(.DATA_W(DATA_W)) u_g (
        .clk  (clk),
        .rst  (Reset),
        .i_ld (w_g_ld),
        .i_d  (w_alu),
        .o_q  (w_g)
    );

    // ------------------------------------------------------------------
    // ALU: A op bus; add/sub wrap modulo 2^DATA_W
    // ------------------------------------------------------------------
    always_comb begin
        w_alu = '0;
        case (w_op)
            OP_ADD:  w_alu = w_a + w_bus;
            OP_SUB:  w_alu = w_a - w_bus;
            OP_AND:  w_alu = w_a & w_bus;
            OP_OR:   w_alu = w_a | w_bus;
            OP_XOR:  w_alu = w_a ^ w_bus;
            default: w_alu = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // State, instruction and flag registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state <= T0;
            r_ir    <= '0;
            r_zero  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            // IR only loads at instruction start, so it is stable in T1..T3
            if (r_state == T0 && Run) begin
                r_ir <= Din[IR_W-1:0];
            end
            if (w_zero_ld) begin
                r_zero <= (w_alu == '0);
            end
        end
    end

    // ------------------------------------------------------------------
    // Next state, bus source select and load strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_bus       = '0;
        w_r_ld      = '0;
        w_a_ld      = 1'b0;
        w_g_ld      = 1'b0;
        w_zero_ld   = 1'b0;
        w_done      = 1'b0;
        w_illegal   = 1'b0;

        case (r_state)
            T0: begin
                if (Run) begin
                    w_state_nxt = T1;
                end
            end
            T1: begin
                case (w_op)
                    OP_MV: begin
                        w_bus        = w_r[w_ry];
                        w_r_ld[w_rx] = 1'b1;
                        w_done       = 1'b1;
                        w_state_nxt  = T0;
                    end
                    OP_MVI: begin
                        w_bus        = Din;
                        w_r_ld[w_rx] = 1'b1;
                        w_done       = 1'b1;
                        w_state_nxt  = T0;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                        w_bus       = w_r[w_rx];
                        w_a_ld      = 1'b1;
                        w_state_nxt = T2;
                    end
                    default: begin
                        // OP_ILL: finish immediately, touch no state
                        w_done      = 1'b1;
                        w_illegal   = 1'b1;
                        w_state_nxt = T0;
                    end
                endcase
            end
            T2: begin
                w_bus       = w_r[w_ry];
                w_g_ld      = 1'b1;
                w_zero_ld   = 1'b1;
                w_state_nxt = T3;
            end
            T3: begin
                w_bus        = w_g;
                w_r_ld[w_rx] = 1'b1;
                w_done       = 1'b1;
                w_state_nxt  = T0;
            end
            default: begin
                w_state_nxt = T0;
            end
        endcase
    end

    assign Bus      = w_bus;
    assign Done     = w_done;
    assign Illegal  = w_illegal;
    assign Busy     = (r_state != T0);
    assign Zero     = r_zero;
    assign dbg_data = w_r[dbg_sel];

endmodule : scu_param

`default_nettype wire

// File: tb/tb_scu_param.sv
// ============================================================================
//  Module      : tb_scu_param
//  Description : Directed self-checking bench for scu_param in the default
//                configuration (16-bit, 8 registers) and a reduced one
//                (8-bit, 4 registers).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_scu_param;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Default configuration: DATA_W=16, NREG=8
    logic        a_reset, a_run;
    logic [15:0] a_din;
    logic [2:0]  a_sel;
    logic [15:0] a_dbg, a_bus;
    logic        a_done, a_busy, a_zero, a_ill;

    // Reduced configuration: DATA_W=8, NREG=4
    logic        b_reset, b_run;
    logic [7:0]  b_din;
    logic [1:0]  b_sel;
    logic [7:0]  b_dbg, b_bus;
    logic        b_done, b_busy, b_zero, b_ill;

    int checks = 0;
    int errors = 0;

    scu_param #(.DATA_W(16), .NREG(8)) u_dut_a (
        .clk(clk), .Reset(a_reset), .Run(a_run), .Din(a_din),
        .dbg_sel(a_sel), .dbg_data(a_dbg), .Bus(a_bus), .Done(a_done),
        .Busy(a_busy), .Zero(a_zero), .Illegal(a_ill)
    );

    scu_param #(.DATA_W(8), .NREG(4)) u_dut_b (
        .clk(clk), .Reset(b_reset), .Run(b_run), .Din(b_din),
        .dbg_sel(b_sel), .dbg_data(b_dbg), .Bus(b_bus), .Done(b_done),
        .Busy(b_busy), .Zero(b_zero), .Illegal(b_ill)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_a(input logic [2:0] sel, input string tag, input logic [15:0] exp);
        a_sel = sel;
        #1;
        check(tag, a_dbg, exp);
    endtask

    task automatic rd_b(input logic [1:0] sel, input string tag, input logic [15:0] exp);
        b_sel = sel;
        #1;
        check(tag, {8'h00, b_dbg}, exp);
    endtask

    // Issue an instruction word in T0; returns settled in T1 with Run low
    task automatic start_a(input logic [15:0] ir);
        a_run = 1'b1;
        a_din = ir;
        step();
        a_run = 1'b0;
        a_din = 16'h0000;
    endtask

    task automatic start_b(input logic [7:0] ir);
        b_run = 1'b1;
        b_din = ir;
        step();
        b_run = 1'b0;
        b_din = 8'h00;
    endtask

    initial begin
        a_reset = 1'b1; a_run = 1'b0; a_din = '0; a_sel = '0;
        b_reset = 1'b1; b_run = 1'b0; b_din = '0; b_sel = '0;
        step();
        step();
        a_reset = 1'b0;
        b_reset = 1'b0;

        // ---- reset state ----
        check("rst_done", {15'd0, a_done}, 16'd0);
        check("rst_busy", {15'd0, a_busy}, 16'd0);
        check("rst_ill",  {15'd0, a_ill},  16'd0);
        check("rst_zero", {15'd0, a_zero}, 16'd0);
        check("rst_bus",  a_bus, 16'h0000);
        rd_a(3'd0, "rst_r0", 16'h0000);

        // ---- mvi R0,5 ----
        start_a(16'b001_000_000);
        a_din = 16'h0005;
        #1;
        check("mvi_t1_done", {15'd0, a_done}, 16'd1);
        check("mvi_t1_busy", {15'd0, a_busy}, 16'd1);
        check("mvi_t1_bus",  a_bus, 16'h0005);
        step();
        a_din = 16'h0000;
        check("mvi_t0_done", {15'd0, a_done}, 16'd0);
        rd_a(3'd0, "mvi_r0", 16'h0005);

        // ---- mv R1,R0 (back-to-back, no idle cycle) ----
        start_a(16'b000_001_000);
        check("mv_t1_done", {15'd0, a_done}, 16'd1);
        check("mv_t1_bus",  a_bus, 16'h0005);
        step();
        rd_a(3'd1, "mv_r1", 16'h0005);

        // ---- add R0,R1 ----
        start_a(16'b010_000_001);
        check("add_t1_done", {15'd0, a_done}, 16'd0);
        check("add_t1_bus",  a_bus, 16'h0005);
        step();
        check("add_t2_done", {15'd0, a_done}, 16'd0);
        step();
        check("add_t3_done", {15'd0, a_done}, 16'd1);
        check("add_t3_bus",  a_bus, 16'h000A);
        step();
        check("add_busy", {15'd0, a_busy}, 16'd0);
        check("add_zero", {15'd0, a_zero}, 16'd0);
        rd_a(3'd0, "add_r0", 16'h000A);

        // ---- sub R2,R1: 0 - 5 wraps ----
        start_a(16'b011_010_001);
        step();
        step();
        check("sub_t3_bus", a_bus, 16'hFFFB);
        step();
        rd_a(3'd2, "sub_r2", 16'hFFFB);
        check("sub_zero0", {15'd0, a_zero}, 16'd0);

        // ---- sub R0,R0 -> zero ----
        start_a(16'b011_000_000);
        step();
        step();
        step();
        rd_a(3'd0, "subz_r0", 16'h0000);
        check("subz_zero1", {15'd0, a_zero}, 16'd1);

        // ---- illegal opcode ----
        start_a(16'b111_011_010);
        check("ill_t1_ill",  {15'd0, a_ill},  16'd1);
        check("ill_t1_done", {15'd0, a_done}, 16'd1);
        check("ill_t1_bus",  a_bus, 16'h0000);
        step();
        check("ill_t0_ill",  {15'd0, a_ill},  16'd0);
        check("ill_zero",    {15'd0, a_zero}, 16'd1);
        rd_a(3'd3, "ill_r3", 16'h0000);
        rd_a(3'd2, "ill_r2", 16'hFFFB);
        rd_a(3'd1, "ill_r1", 16'h0005);

        // ---- add R1,R1 with Run held high and junk on Din mid-instruction ----
        a_run = 1'b1;
        a_din = 16'b010_001_001;
        step();
        a_din = 16'b001_111_111;
        step();
        step();
        check("dbl_t3_bus", a_bus, 16'h000A);
        step();
        a_run = 1'b0;
        a_din = 16'h0000;
        check("dbl_busy", {15'd0, a_busy}, 16'd0);
        rd_a(3'd1, "dbl_r1", 16'h000A);
        rd_a(3'd7, "dbl_r7", 16'h0000);

        // ---- reset during T2 of add R0,R1 ----
        start_a(16'b010_000_001);
        step();
        a_reset = 1'b1;
        step();
        a_reset = 1'b0;
        check("rt2_busy", {15'd0, a_busy}, 16'd0);
        check("rt2_done", {15'd0, a_done}, 16'd0);
        check("rt2_bus",  a_bus, 16'h0000);
        rd_a(3'd0, "rt2_r0", 16'h0000);
        rd_a(3'd1, "rt2_r1", 16'h0000);
        start_a(16'b001_100_000);
        a_din = 16'h1234;
        #1;
        check("rt2_mvi_done", {15'd0, a_done}, 16'd1);
        step();
        a_din = 16'h0000;
        rd_a(3'd4, "rt2_r4", 16'h1234);

        // ---- reduced configuration ----
        start_b(8'b001_11_11);
        b_din = 8'hFF;
        #1;
        check("b_mvi3_done", {15'd0, b_done}, 16'd1);
        step();
        start_b(8'b001_10_00);
        b_din = 8'h01;
        step();
        rd_b(2'd3, "b_r3", 16'h00FF);
        rd_b(2'd2, "b_r2", 16'h0001);
        start_b(8'b010_11_10);
        step();
        step();
        check("b_add_t3_bus", {8'h00, b_bus}, 16'h0000);
        check("b_add_done",   {15'd0, b_done}, 16'd1);
        step();
        rd_b(2'd3, "b_add_r3", 16'h0000);
        check("b_add_zero", {15'd0, b_zero}, 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_scu_param

`default_nettype wire

// File: doc/scu_param.md
SCU_PARAM -- requirements
Module: scu_param

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning datapath, register and bus width in bits.
REQ-002 SHALL have parameter NREG, default 8, meaning number of general registers; legal values 2, 4, 8.
REQ-003 SHALL derive RSEL_W = clog2(NREG) and IR_W = 3 + 2*RSEL_W; DATA_W < IR_W SHALL be rejected at elaboration.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port Run, input, 1 bit: instruction-start request, sampled only in state T0.
REQ-007 SHALL have port Din, input, DATA_W bits: instruction word in T0 (bits IR_W-1:0) and immediate in T1.
REQ-008 SHALL have port dbg_sel, input, RSEL_W bits: register-read select for verification.
REQ-009 SHALL have port dbg_data, output, DATA_W bits: combinational contents of register dbg_sel.
REQ-010 SHALL have port Bus, output, DATA_W bits: current internal bus value.
REQ-011 SHALL have port Done, output, 1 bit: high during the final cycle of an instruction.
REQ-012 SHALL have port Busy, output, 1 bit: high in every state except T0.
REQ-013 SHALL have port Zero, output, 1 bit: registered flag, 1 when the last ALU result was 0.
REQ-014 SHALL have port Illegal, output, 1 bit: one-cycle pulse for an undefined opcode.

Function
REQ-015 SHALL decode IR as op = IR[IR_W-1 -: 3], rX = next RSEL_W bits, rY = low RSEL_W bits.
REQ-016 SHALL implement FSM states T0, T1, T2, T3; in T0 with Run=1, IR <= Din[IR_W-1:0] and next state T1; with Run=0, remain in T0.
REQ-017 SHALL ignore Run outside T0; the instruction word never changes mid-instruction.
REQ-018 SHALL execute op 000 mv: T1 bus=R[rY], R[rX]<=bus, Done=1, next T0.
REQ-019 SHALL execute op 001 mvi: T1 bus=Din, R[rX]<=Din, Done=1, next T0.
REQ-020 SHALL execute ops 010 add, 011 sub, 100 and, 101 or, 110 xor: T1 bus=R[rX], A<=bus; T2 bus=R[rY], G<=A op bus, Zero<=(result==0); T3 bus=G, R[rX]<=G, Done=1, next T0.
REQ-021 SHALL treat op 111 as illegal: T1 Done=1, Illegal=1, no register, A, G or Zero update, next T0.
REQ-022 SHALL compute add/sub modulo 2^DATA_W with no carry or borrow output; rX==rY SHALL be legal (add R1,R1 doubles R1).
REQ-023 SHALL drive the bus through exactly one selected source per cycle; in T0, and in any cycle with no source, Bus SHALL be 0 (no latch, no hold).
REQ-024 SHALL keep Done and Illegal combinational from state and IR, each high for exactly one cycle per instruction.
REQ-025 SHALL accept a new Run in the T0 cycle immediately after Done (back-to-back instructions, no idle gap).

Reset
REQ-026 SHALL, on Reset=1 at a rising edge, set state T0 and clear IR, all registers, A, G and Zero; Done, Busy, Illegal and Bus SHALL be 0 in the following cycle.
REQ-027 SHALL give Reset priority over Run and over any in-flight write; an instruction interrupted mid-execution SHALL leave no register modified.

Structure
REQ-028 SHALL place opcode constants (OP_MV..OP_ILL) and the state enumeration in shared package scu_pkg.
REQ-029 SHALL instantiate a parametrised register sub-module scu_reg (width DATA_W, load enable, synchronous clear) for R0..R(NREG-1), A and G.
REQ-030 SHALL keep the ALU and the bus multiplexer as combinational logic inside scu_param.

Verification
REQ-031 SHALL cover mvi then mv (DATA_W=16, NREG=8): Run with Din=9'b001_000_000, then Din=0x0005 in T1 -> Done in T1, R0=5; then 9'b000_001_000 -> R1=5 after one execution cycle.
REQ-032 SHALL cover add: R0=5, R1=5, IR 9'b010_000_001 -> Done in the third cycle after T0, R0=10, Zero=0.
REQ-033 SHALL cover sub underflow and Zero: R2=0, R1=5, sub R2,R1 -> R2=0xFFFB, Zero=0; then sub R0,R0 -> R0=0, Zero=1.
REQ-034 SHALL cover illegal opcode: IR 9'b111_011_010 -> Illegal=1 and Done=1 in T1, all registers unchanged.
REQ-035 SHALL cover Reset asserted in T2 of add R0,R1 -> next cycle state T0, Busy=0, Done=0, R0=0; a new Run then executes normally.
REQ-036 SHALL cover a second configuration, DATA_W=8, NREG=4 (IR_W=7): mvi R3,0xFF; mvi R2,1; add R3,R2 -> R3=0x00, Zero=1.
